// File: rtl/l1_trigger_receiver_if.sv
// ---------------------------------------------------------------------------
// l1_trigger_receiver_if
// Event hand-off bundle between an L1 trigger receiver and its consumer.
//   evt_valid : holding register full (receiver -> consumer)
//   evt_ready : consumer takes the event when high with evt_valid
//   evt_time  : timestamp of the held event (receiver -> consumer)
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface l1_trigger_receiver_if #(
   parameter int unsigned TS_W = 16
);
   logic            evt_valid;
   logic            evt_ready;
   logic [TS_W-1:0] evt_time;

   modport master (
      output evt_valid,
      output evt_time,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_time,
      output evt_ready
   );
endinterface

// File: rtl/l1_trigger_receiver.sv
// ---------------------------------------------------------------------------
// l1_trigger_receiver
// Turns one asynchronous SURF L1 line into qualified, timestamped trigger
// events: two-flop synchronizer, minimum-width glitch filter, holdoff
// deadtime, single-entry event holding register with drop counting, and an
// accepted-trigger scaler latched on every REF_PULSE rising edge.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_l1_in        asynchronous L1 line from the SURF
//   i_ref_pulse    synchronous scaler-latch strobe (rising edge used)
//   evt_if         master side of l1_trigger_receiver_if (valid/ready/time)
//   o_drop_count   saturating count of events lost to backpressure
//   o_scaler_out   accepted-trigger count of the last REF_PULSE interval
//   o_scaler_valid one-cycle strobe when o_scaler_out updates
//   o_glitch_count saturating count of rejected short pulses
//
// Build option
//   L1_RX_GLITCH_COUNT_EN : when defined, o_glitch_count counts every
//   QUAL->IDLE reject; otherwise the counter is absent and the port is 0.
//
// FSM
//   state      | meaning
//   -----------+---------------------------------------------------------
//   S_IDLE     | armed, waiting for a synchronized low->high edge
//   S_QUAL     | line high, counting width toward MIN_WIDTH
//   S_WAIT_LOW | trigger accepted, waiting for the line to return low
//   S_HOLDOFF  | deadtime after the line fell; line activity ignored
// ---------------------------------------------------------------------------
module l1_trigger_receiver #(
   parameter int unsigned MIN_WIDTH = 2,
   parameter int unsigned HOLDOFF   = 8,
   parameter int unsigned TS_W      = 16,
   parameter int unsigned SCALER_W  = 16
)(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_l1_in,
   input  logic                         i_ref_pulse,
   l1_trigger_receiver_if.master        evt_if,
   output logic [7:0]                   o_drop_count,
   output logic [SCALER_W-1:0]          o_scaler_out,
   output logic                         o_scaler_valid,
   output logic [7:0]                   o_glitch_count
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_QUAL     = 2'd1,
      S_WAIT_LOW = 2'd2,
      S_HOLDOFF  = 2'd3
   } state_t;

   localparam logic [3:0] MIN_W     = 4'(MIN_WIDTH);
   localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF - 1);

   // ---------------------------------------------------------------------
   // Synchronizer, previous-sample and sample-valid tracking
   // ---------------------------------------------------------------------
   logic       r_sync0;
   logic       r_sync1;
   logic       r_l1_prev;
   logic [2:0] r_vld;
   logic       w_l1_rise;

   // r_vld marks which of sync0/sync1/prev hold real samples of the line
   // rather than reset values. Without it a line already high at reset
   // release would look like a fresh edge against the reset-zero history.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync0   <= 1'b0;
         r_sync1   <= 1'b0;
         r_l1_prev <= 1'b0;
         r_vld     <= 3'b000;
      end else begin
         r_sync0   <= i_l1_in;
         r_sync1   <= r_sync0;
         r_l1_prev <= r_sync1;
         r_vld     <= {r_vld[1:0], 1'b1};
      end
   end

   assign w_l1_rise = r_sync1 & ~r_l1_prev & r_vld[2];

   // ---------------------------------------------------------------------
   // Free-running timestamp
   // ---------------------------------------------------------------------
   logic [TS_W-1:0] r_ts;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + TS_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Qualification FSM
   // ---------------------------------------------------------------------
   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_width;
   logic [3:0]      w_width_nxt;
   logic [7:0]      r_hold;
   logic [7:0]      w_hold_nxt;
   logic [TS_W-1:0] r_cap_ts;
   logic            w_cap_load;
   logic            w_accept;
   logic            w_reject;
   logic [TS_W-1:0] w_acc_ts;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_width  <= 4'd0;
         r_hold   <= 8'd0;
         r_cap_ts <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_width <= w_width_nxt;
         r_hold  <= w_hold_nxt;
         if (w_cap_load) begin
            r_cap_ts <= r_ts;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_width_nxt = r_width;
      w_hold_nxt  = r_hold;
      w_cap_load  = 1'b0;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_l1_rise) begin
               w_cap_load  = 1'b1;
               w_width_nxt = 4'd1;
               if (MIN_W == 4'd1) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_WAIT_LOW;
               end else begin
                  w_state_nxt = S_QUAL;
               end
            end
         end
         S_QUAL: begin
            if (r_sync1) begin
               w_width_nxt = r_width + 4'd1;
               if (r_width + 4'd1 == MIN_W) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_WAIT_LOW;
               end
            end else begin
               w_reject    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT_LOW: begin
            if (!r_sync1) begin
               w_hold_nxt  = HOLD_INIT;
               w_state_nxt = S_HOLDOFF;
            end
         end
         S_HOLDOFF: begin
            if (r_hold == 8'd0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_hold_nxt = r_hold - 8'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // An accept straight out of IDLE (MIN_WIDTH = 1) happens in the same
   // cycle the capture register loads, so take the live timestamp then.
   assign w_acc_ts = (r_state == S_IDLE) ? r_ts : r_cap_ts;

   // ---------------------------------------------------------------------
   // Event holding register and drop counter
   // ---------------------------------------------------------------------
   logic            r_evt_valid;
   logic [TS_W-1:0] r_evt_time;
   logic [7:0]      r_drop;
   logic            w_hs;

   assign w_hs = r_evt_valid & evt_if.evt_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_evt_valid <= 1'b0;
         r_evt_time  <= '0;
         r_drop      <= 8'd0;
      end else begin
         if (w_accept) begin
            if (!r_evt_valid || w_hs) begin
               r_evt_valid <= 1'b1;
               r_evt_time  <= w_acc_ts;
            end else if (r_drop != 8'hFF) begin
               r_drop <= r_drop + 8'd1;
            end
         end else if (w_hs) begin
            r_evt_valid <= 1'b0;
         end
      end
   end

   assign evt_if.evt_valid = r_evt_valid;
   assign evt_if.evt_time  = r_evt_time;
   assign o_drop_count     = r_drop;

   // ---------------------------------------------------------------------
   // Accepted-trigger scaler
   // ---------------------------------------------------------------------
   logic                r_ref_prev;
   logic                w_ref_rise;
   logic [SCALER_W-1:0] r_cnt;
   logic [SCALER_W-1:0] r_scaler_out;
   logic                r_scaler_valid;

   assign w_ref_rise = i_ref_pulse & ~r_ref_prev;

   // An accept on the latch edge belongs to the new interval, so it seeds
   // the counter with 1 instead of being folded into the latched value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ref_prev     <= 1'b0;
         r_cnt          <= '0;
         r_scaler_out   <= '0;
         r_scaler_valid <= 1'b0;
      end else begin
         r_ref_prev     <= i_ref_pulse;
         r_scaler_valid <= w_ref_rise;
         if (w_ref_rise) begin
            r_scaler_out <= r_cnt;
            r_cnt        <= w_accept ? SCALER_W'(1) : '0;
         end else if (w_accept && (r_cnt != '1)) begin
            r_cnt <= r_cnt + SCALER_W'(1);
         end
      end
   end

   assign o_scaler_out   = r_scaler_out;
   assign o_scaler_valid = r_scaler_valid;

   // ---------------------------------------------------------------------
   // Optional glitch counter
   // ---------------------------------------------------------------------
`ifdef L1_RX_GLITCH_COUNT_EN
   logic [7:0] r_glitch;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_glitch <= 8'd0;
      end else if (w_reject && (r_glitch != 8'hFF)) begin
         r_glitch <= r_glitch + 8'd1;
      end
   end

   assign o_glitch_count = r_glitch;
`else
   logic w_unused_reject;

   assign w_unused_reject = w_reject;
   assign o_glitch_count  = 8'd0;
`endif

endmodule

// File: doc/l1_trigger_receiver.md
# l1_trigger_receiver

Receive-side counterpart of the SURF L1 trigger output: it takes the registered, IOB-driven 2-of-3 L1 line arriving from a SURF and turns it into qualified trigger events. It synchronizes the line, rejects glitches shorter than a programmable width, and enforces a holdoff deadtime. Each accepted trigger is timestamped and presented on a ready/valid interface, and accepted triggers are counted into a scaler latched on each REF_PULSE. It sits on the TURF side, one instance per incoming SURF L1 line.

## Interface
- MIN_WIDTH, 2, minimum consecutive high cycles (of synchronized L1) for acceptance; legal 1..15
- HOLDOFF, 8, deadtime cycles after L1 returns low before a new edge is considered; legal 1..255
- TS_W, 16, timestamp width
- SCALER_W, 16, scaler width
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- L1_IN  in  1  asynchronous L1 line from SURF
- REF_PULSE  in  1  synchronous scaler-latch strobe (rising edge used)
- EVT_VALID  out  1  event holding register full
- EVT_READY  in  1  consumer accepts event when high with EVT_VALID
- EVT_TIME  out  TS_W  timestamp of held event
- DROP_COUNT  out  8  saturating count of events lost to backpressure
- SCALER_OUT  out  SCALER_W  accepted-trigger count of last REF_PULSE interval
- SCALER_VALID  out  1  one-cycle strobe when SCALER_OUT updates
- GLITCH_COUNT  out  8  saturating count of rejected short pulses (see Configuration)

## Operation
- Sync: L1_IN → sync0 → sync1 (= l1_s); l1_prev = l1_s delayed one cycle.
- Timestamp counter ts: free-running, +1 per cycle, wraps 2^TS_W−1 → 0.
- FSM states IDLE, QUAL, WAIT_LOW, HOLDOFF:
  - IDLE: l1_s & ~l1_prev → latch cap_ts = ts; width = 1; if MIN_WIDTH = 1, accept and → WAIT_LOW, else → QUAL.
  - QUAL: l1_s = 1 → width+1; when width+1 = MIN_WIDTH, accept and → WAIT_LOW. l1_s = 0 → reject (glitch) → IDLE.
  - WAIT_LOW: stay while l1_s = 1; l1_s = 0 → HOLDOFF, hold = HOLDOFF−1.
  - HOLDOFF: hold = 0 → IDLE, else hold−1. L1 activity ignored; a line still or again high on entering IDLE needs a fresh low→high edge.
- Accept loads cap_ts into the holding register:
  - Register empty, or EVT_VALID & EVT_READY in the same cycle: load, EVT_VALID = 1.
  - EVT_VALID & ~EVT_READY: event dropped, DROP_COUNT +1, saturating at 255.
- EVT_VALID & EVT_READY with no accept: EVT_VALID = 0 next cycle.
- Scaler: cnt +1 per accept, saturating at all-ones.
  - REF_PULSE rising edge (REF_PULSE & ~ref_prev): SCALER_OUT = cnt, SCALER_VALID = 1 for one cycle, cnt = 0.
  - Accept coincident with the REF_PULSE edge: excluded from the latched value; cnt = 1.
- Reset: all outputs 0, ts = 0, FSM IDLE, sync/prev registers 0, counters 0. Reset mid-event discards the held event and any partial qualification; after release, a line already high is not accepted until it goes low and rises again.

## Timing
- L1_IN high first sampled at edge n: sync1 = 1 after n+1; IDLE→QUAL at edge n+2, cap_ts = ts value before edge n+2.
- Accept at edge n+1+MIN_WIDTH; EVT_VALID high after that edge. Default latency: EVT_VALID rises 3 cycles after the first sampling edge.
- Pulse of exactly MIN_WIDTH synchronized cycles is accepted; MIN_WIDTH−1 is rejected.
- Minimum event spacing: MIN_WIDTH + 1 + HOLDOFF cycles, plus one low cycle for re-arm.
- SCALER_VALID asserts one cycle after the edge registering the REF_PULSE rise.

## Configuration
- L1_RX_GLITCH_COUNT_EN defined: GLITCH_COUNT +1 (saturating at 255) on every QUAL→IDLE reject.
- Not defined: counter logic omitted; GLITCH_COUNT tied to 0. FSM behaviour is identical in both builds.

## Test plan
- Reset, L1_IN high 3 cycles, EVT_READY = 1 → one EVT_VALID pulse 3 cycles after the first sampling edge; EVT_TIME = ts at qualification start; SCALER count 1.
- L1_IN high 1 cycle (MIN_WIDTH = 2) → no event; GLITCH_COUNT = 1 with macro, 0 without.
- Two 4-cycle pulses separated by 5 low cycles (HOLDOFF = 8) → second ignored; separated by 12 low cycles → two events.
- EVT_READY = 0, three spaced qualified pulses → EVT_VALID held with first timestamp; DROP_COUNT = 2; READY = 1 → EVT_VALID drops next cycle.
- 5 triggers, then REF_PULSE rise coincident with a 6th accept → SCALER_OUT = 5, SCALER_VALID one cycle; next interval starts at 1.
- RST asserted while in QUAL with L1_IN held high → outputs 0; after release, no event until L1_IN goes low then high.
